// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the SRAM-backed memory stage.
package sram_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEF_WAIT_CYC  = 5;
  localparam int DEF_BASE_ADDR = 1024;

  // Number of SRAM beats needed to move one CPU word.
  function automatic int calc_beats(input int data_w, input int sram_dw);
    return data_w / sram_dw;
  endfunction

  // Width of the per-beat cycle counter.
  function automatic int cyc_cnt_w(input int wait_cyc);
    return (wait_cyc > 1) ? $clog2(wait_cyc) : 1;
  endfunction

  // Beat counter carries one extra bit so a single-beat configuration still
  // gets a legal, non-zero-width counter.
  function automatic int beat_cnt_w(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Cycle/beat counters for one SRAM access: flags the last cycle of every beat
// and the last cycle of the whole access.
module sram_beat_timer
  import sram_pkg::*;
#(
  parameter  int WAIT_CYC = DEF_WAIT_CYC,
  parameter  int BEATS    = 2,
  localparam int CW       = cyc_cnt_w(WAIT_CYC),
  localparam int BW       = beat_cnt_w(BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_run,
  output logic [BW-1:0] o_beat_cnt,
  output logic          o_beat_last_cyc,
  output logic          o_access_done
);

  logic [CW-1:0] r_cyc_cnt;
  logic [BW-1:0] r_beat_cnt;
  logic          w_beat_last_cyc;

  assign w_beat_last_cyc = i_run && (r_cyc_cnt == CW'(WAIT_CYC - 1));
  assign o_beat_last_cyc = w_beat_last_cyc;
  assign o_access_done   = w_beat_last_cyc && (r_beat_cnt == BW'(BEATS - 1));
  assign o_beat_cnt      = r_beat_cnt;

  // Count cycles within a beat, then step to the next beat; cleared on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc_cnt  <= '0;
      r_beat_cnt <= '0;
    end else if (i_start) begin
      r_cyc_cnt  <= '0;
      r_beat_cnt <= '0;
    end else if (i_run) begin
      if (w_beat_last_cyc) begin
        r_cyc_cnt  <= '0;
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end else begin
        r_cyc_cnt <= r_cyc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_mem_stage.sv
// MEM-stage load/store through an external asynchronous SRAM. A CPU word is
// moved as several narrower beats, each WAIT_CYC cycles long; ready freezes
// the pipeline from the request cycle until the access completes.
module sram_mem_stage
  import sram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int SRAM_AW   = 18,
  parameter int SRAM_DW   = 16,
  parameter int WAIT_CYC  = DEF_WAIT_CYC,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);

  localparam int BEATS   = calc_beats(DATA_W, SRAM_DW);
  localparam int BW      = beat_cnt_w(BEATS);
  localparam int BYTE_SH = $clog2(DATA_W / 8);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_op_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [SRAM_AW-1:0]  r_sram_addr;

  logic                w_req;
  logic                w_start;
  logic                w_run;
  logic                w_beat_last_cyc;
  logic                w_access_done;
  logic [BW-1:0]       w_beat_cnt;
  logic [ADDR_W-1:0]   w_offset;
  logic [ADDR_W-1:0]   w_word_idx;
  logic [ADDR_W-1:0]   w_scaled;
  logic [SRAM_AW-1:0]  w_first_addr;

  assign w_req = wr_en | rd_en;
  assign w_run = (r_state == ST_ACCESS);

  // Byte address -> SRAM word of beat 0. Misaligned low bits drop out in the
  // shift; anything outside the SRAM window wraps through the truncation.
  assign w_offset     = addr - ADDR_W'(BASE_ADDR);
  assign w_word_idx   = w_offset >> BYTE_SH;
  assign w_scaled     = w_word_idx * ADDR_W'(BEATS);
  assign w_first_addr = w_scaled[SRAM_AW-1:0];

  sram_beat_timer #(
    .WAIT_CYC (WAIT_CYC),
    .BEATS    (BEATS)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .i_start         (w_start),
    .i_run           (w_run),
    .o_beat_cnt      (w_beat_cnt),
    .o_beat_last_cyc (w_beat_last_cyc),
    .o_access_done   (w_access_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state and ready. ready is combinational in IDLE so the freeze
  // coincides with the cycle the request first appears.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a latch.
    w_next_state = r_state;
    ready        = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = ~w_req;
        if (w_req) begin
          w_start      = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (w_access_done) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        ready        = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Latch the request, step the SRAM address per beat, capture read beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_wr     <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
    end else if (w_start) begin
      // A simultaneous write and read resolves to the write.
      r_op_wr     <= wr_en;
      r_wdata     <= wdata;
      r_sram_addr <= w_first_addr;
    end else if (w_run && w_beat_last_cyc) begin
      if (!r_op_wr) r_rdata[w_beat_cnt*SRAM_DW +: SRAM_DW] <= sram_dq_in;
      if (!w_access_done) r_sram_addr <= r_sram_addr + 1'b1;
    end
  end

  // SRAM strobes: data driven for the whole write beat, we_n released on the
  // final cycle so address and data are held past the write edge.
  always_comb begin
    sram_dq_oe  = w_run && r_op_wr;
    sram_we_n   = ~(sram_dq_oe && !w_beat_last_cyc);
    sram_dq_out = '0;
    if (sram_dq_oe) sram_dq_out = r_wdata[w_beat_cnt*SRAM_DW +: SRAM_DW];
  end

  assign rdata     = r_rdata;
  assign sram_addr = r_sram_addr;

endmodule

// File: tb/tb_sram_mem_stage.sv
// Self-checking bench for sram_mem_stage: default 32/16-bit instance driven
// from a vector table, plus a single-beat 32/32-bit instance.
module tb_sram_mem_stage;

  localparam int WAIT  = 5;
  localparam int BEATS = 2;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [17:0] exp_base;
  } vec_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        v_wr_en, v_rd_en;
  logic [31:0] v_addr, v_wdata, v_rdata;
  logic        v_ready;
  logic [17:0] v_sram_addr;
  logic [31:0] v_sram_dq_out, v_sram_dq_in;
  logic        v_sram_dq_oe, v_sram_we_n;

  logic [15:0] mem   [64] = '{default: 16'h0000};
  logic [31:0] mem32 [4]  = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0};

  int    n_checks = 0;
  int    n_err    = 0;
  beat_t wq[$];
  logic [31:0] rq[$];
  vec_t  vecs[7];

  sram_mem_stage u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  sram_mem_stage #(
    .DATA_W(32), .ADDR_W(32), .SRAM_AW(18), .SRAM_DW(32),
    .WAIT_CYC(2), .BASE_ADDR(1024)
  ) u_dut32 (
    .clk(clk), .rst(rst), .wr_en(v_wr_en), .rd_en(v_rd_en), .addr(v_addr),
    .wdata(v_wdata), .rdata(v_rdata), .ready(v_ready), .sram_addr(v_sram_addr),
    .sram_dq_out(v_sram_dq_out), .sram_dq_oe(v_sram_dq_oe),
    .sram_dq_in(v_sram_dq_in), .sram_we_n(v_sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM models: combinational read, write while we_n is low.
  assign sram_dq_in   = mem[sram_addr[5:0]];
  assign v_sram_dq_in = mem32[v_sram_addr[1:0]];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] er,
                              input logic [17:0] base);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_base = base;
    return v;
  endfunction

  // Write-beat monitor: each falling we_n must match the next expected beat,
  // and each completed beat must have held we_n low for WAIT-1 cycles.
  logic prev_we_n = 1'b1;
  int   low_cnt   = 0;
  always @(negedge clk) begin
    beat_t b;
    if (!sram_we_n && prev_we_n) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write_beat: addr %0h data %0h with nothing queued", sram_addr, sram_dq_out);
      end else begin
        b = wq.pop_front();
        check("wbeat_addr", 64'(sram_addr), 64'(b.addr));
        check("wbeat_data", 64'(sram_dq_out), 64'(b.data));
      end
      low_cnt = 1;
    end else if (!sram_we_n) begin
      low_cnt++;
    end else if (!prev_we_n && sram_dq_oe) begin
      check("we_n_low_cycles", 64'(low_cnt), 64'(WAIT - 1));
    end
    prev_we_n = sram_we_n;
  end

  task automatic run_txn(input vec_t v);
    int   low;
    logic done;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    wr_en = v.wr; rd_en = v.rd; addr = v.addr; wdata = v.wdata;
    if (v.wr) begin
      wq.push_back('{addr: v.exp_base,       data: v.wdata[15:0]});
      wq.push_back('{addr: v.exp_base + 18'd1, data: v.wdata[31:16]});
    end
    rq.push_back(v.exp_rdata);
    @(negedge clk);
    check("freeze_same_cycle", 64'(ready), 64'(0));
    @(posedge clk); #1;
    // Scramble inputs during the access; only latched values may matter.
    wr_en = 1'b0; rd_en = 1'b0; addr = $urandom; wdata = $urandom;
    low = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      else low++;
    end
    check("done_reached", 64'(done), 64'(1));
    check("ready_low_cycles", 64'(low), 64'(BEATS * WAIT));
    exp_rd = rq.pop_front();
    check("rdata_done", 64'(rdata), 64'(exp_rd));
    @(negedge clk);
    check("ready_idle_after", 64'(ready), 64'(1));
    check("rdata_held", 64'(rdata), 64'(exp_rd));
    if (v.wr) begin
      check("mem_lo", 64'(mem[v.exp_base[5:0]]), 64'(v.wdata[15:0]));
      check("mem_hi", 64'(mem[v.exp_base[5:0] + 6'd1]), 64'(v.wdata[31:16]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int   low;
    logic done;

    vecs[0] = mk(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000, 18'd2);
    vecs[1] = mk(1'b0, 1'b1, 32'd1028, 32'h0,        32'hDEADBEEF, 18'd2);
    vecs[2] = mk(1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 18'd4);
    vecs[3] = mk(1'b0, 1'b1, 32'd1032, 32'h0,        32'h12345678, 18'd4);
    vecs[4] = mk(1'b1, 1'b0, 32'd1020, 32'hAABBCCDD, 32'h12345678, 18'h3FFFE);
    vecs[5] = mk(1'b0, 1'b1, 32'd1020, 32'h0,        32'hAABBCCDD, 18'h3FFFE);
    vecs[6] = mk(1'b0, 1'b1, 32'd1031, 32'h0,        32'hDEADBEEF, 18'd2);

    rst = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    v_wr_en = 1'b0; v_rd_en = 1'b0; v_addr = '0; v_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sram_addr", 64'(sram_addr), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_we_n", 64'(sram_we_n), 64'(1));
    check("rst_dq_oe", 64'(sram_dq_oe), 64'(0));
    check("rst_ready", 64'(ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle with no request.
    repeat (5) begin
      @(negedge clk);
      check("idle_ready", 64'(ready), 64'(1));
      check("idle_we_n", 64'(sram_we_n), 64'(1));
      check("idle_dq_oe", 64'(sram_dq_oe), 64'(0));
    end

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset during the fourth cycle of beat 0 of a write.
    @(posedge clk); #1;
    wr_en = 1'b1; addr = 32'd1040; wdata = 32'h55AA33CC;
    wq.push_back('{addr: 18'd8, data: 16'h33CC});
    wq.push_back('{addr: 18'd9, data: 16'h55AA});
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_we_n", 64'(sram_we_n), 64'(0));
    check("pre_rst_rdata", 64'(rdata), 64'hDEADBEEF);
    rst = 1'b0;
    #1;
    check("mid_rst_we_n", 64'(sram_we_n), 64'(1));
    check("mid_rst_dq_oe", 64'(sram_dq_oe), 64'(0));
    check("mid_rst_rdata", 64'(rdata), 64'(0));
    check("mid_rst_sram_addr", 64'(sram_addr), 64'(0));
    check("mid_rst_ready", 64'(ready), 64'(1));
    wq.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(ready), 64'(1));
    check("post_rst_we_n", 64'(sram_we_n), 64'(1));
    run_txn(mk(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 18'd2));

    // Single-beat variant: 32-bit SRAM, two cycles per beat.
    @(posedge clk); #1;
    v_rd_en = 1'b1; v_addr = 32'd1024;
    @(negedge clk);
    check("v_freeze", 64'(v_ready), 64'(0));
    @(posedge clk); #1;
    v_rd_en = 1'b0; v_addr = $urandom;
    low = 0; done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (v_ready) done = 1'b1;
      else low++;
    end
    check("v_done_reached", 64'(done), 64'(1));
    check("v_ready_low_cycles", 64'(low), 64'(2));
    check("v_rdata", 64'(v_rdata), 64'hCAFEF00D);
    check("v_we_n", 64'(v_sram_we_n), 64'(1));

    repeat (2) @(negedge clk);
    check("write_queue_drained", 64'(wq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
